// File: rtl/game_pkg.sv
// Shared types for the Chicken Cha Cha Cha game-flow blocks.
// State encodings, player/tile widths and the turn-wrap helper.
package game_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int PW = 2;
  localparam int XW = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_REVEAL = 3'd2,
    S_ADV    = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_WIN    = 3'd6
  } state_t;

  function automatic logic [PW-1:0] next_turn(
    input logic [PW-1:0] t,
    input int            np
  );
    return (int'(t) == np - 1) ? '0 : t + 1'b1;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Game-side signal bundle of the turn scheduler.
// master = scheduler, slave = board/check_win side.
interface turn_scheduler_if;
  import game_pkg::*;

  logic          start;
  logic          btn;
  logic [XW-1:0] flip_sel;
  logic          match;
  logic          W;
  logic [PW-1:0] T;
  logic          advance;
  logic          reveal_en;
  logic [XW-1:0] reveal_idx;
  logic [PW-1:0] winner;
  logic          game_over;
  logic [2:0]    state;

  modport master (
    input  start, btn, flip_sel, match, W,
    output T, advance, reveal_en, reveal_idx,
    output winner, game_over, state
  );

  modport slave (
    output start, btn, flip_sel, match, W,
    input  T, advance, reveal_en, reveal_idx,
    input  winner, game_over, state
  );

endinterface

// File: rtl/reveal_timer.sv
// Reveal interval counter: clear, enable, terminal count.
// Saturates at CYCLES-1 until the next clear.
module reveal_timer #(
  parameter int CYCLES = 50000000,
  parameter int TW     = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TW-1:0] r_cnt;

  assign o_tc = (r_cnt == TW'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencing FSM for the four-player board game.
// Outputs are registered; advance is high only in ADVANCE.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS   = 4,
  parameter int REVEAL_CYCLES = 50000000
) (
  input logic              clk,
  input logic              rst,
  turn_scheduler_if.master bus
);

  localparam int TW = $clog2(REVEAL_CYCLES + 1);

  state_t        r_state;
  logic [PW-1:0] r_t;
  logic          r_adv;
  logic          r_ren;
  logic [XW-1:0] r_idx;
  logic [PW-1:0] r_win;
  logic          r_go;
  logic          r_btn_d;

  logic w_press;
  logic w_clr;
  logic w_en;
  logic w_tc;

  assign w_press = bus.btn & ~r_btn_d;
  assign w_clr   = (r_state == S_WAIT) & w_press;
  assign w_en    = (r_state == S_REVEAL);

  reveal_timer #(
    .CYCLES (REVEAL_CYCLES),
    .TW     (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_adv   <= 1'b0;
      r_ren   <= 1'b0;
      r_idx   <= '0;
      r_win   <= '0;
      r_go    <= 1'b0;
      r_btn_d <= 1'b1;
    end else begin
      r_btn_d <= bus.btn;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_WAIT;
            r_t     <= '0;
          end
        end
        S_WAIT: begin
          if (w_press) begin
            r_idx   <= bus.flip_sel;
            r_ren   <= 1'b1;
            r_state <= S_REVEAL;
          end
        end
        S_REVEAL: begin
          // reveal_en tracks REVEAL exactly, so it drops on exit
          if (w_tc) begin
            r_ren   <= 1'b0;
            r_adv   <= bus.match;
            r_state <= bus.match ? S_ADV : S_NEXT;
          end
        end
        S_ADV: begin
          r_adv   <= 1'b0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.W) begin
            r_win   <= r_t;
            r_go    <= 1'b1;
            r_state <= S_WIN;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_NEXT: begin
          r_t     <= next_turn(r_t, NUM_PLAYERS);
          r_state <= S_WAIT;
        end
        S_WIN: begin
          if (bus.start) begin
            r_state <= S_IDLE;
            r_go    <= 1'b0;
            r_win   <= '0;
            r_t     <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_adv   <= 1'b0;
          r_ren   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.T          = r_t;
  assign bus.advance    = r_adv;
  assign bus.reveal_en  = r_ren;
  assign bus.reveal_idx = r_idx;
  assign bus.winner     = r_win;
  assign bus.game_over  = r_go;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized + directed bench for turn_scheduler.
// Two DUTs (4 and 3 players) share stimulus; each has its own model.
module tb_turn_scheduler;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn;
  logic [3:0] flip_sel;
  logic       match;
  logic       W;
  bit         chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  turn_scheduler_if if4 ();
  turn_scheduler_if if3 ();

  assign if4.start = start;
  assign if4.btn = btn;
  assign if4.flip_sel = flip_sel;
  assign if4.match = match;
  assign if4.W = W;
  assign if3.start = start;
  assign if3.btn = btn;
  assign if3.flip_sel = flip_sel;
  assign if3.match = match;
  assign if3.W = W;

  turn_scheduler #(
    .NUM_PLAYERS   (4),
    .REVEAL_CYCLES (RC)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  turn_scheduler #(
    .NUM_PLAYERS   (3),
    .REVEAL_CYCLES (RC)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  // Game-level model: phase number is the spec's state value,
  // age counts cycles the tile has been shown.
  typedef struct {
    int st;
    int t;
    int idx;
    int win;
    int age;
    bit adv;
    bit ren;
    bit go;
    bit bd;
  } model_t;

  model_t m4;
  model_t m3;

  function automatic model_t rst_m();
    model_t r;
    r.st = 0; r.t = 0; r.idx = 0; r.win = 0; r.age = 0;
    r.adv = 0; r.ren = 0; r.go = 0; r.bd = 1;
    return r;
  endfunction

  function automatic model_t step(model_t m, int np);
    model_t n = m;
    bit press = btn && !m.bd;
    n.bd = btn;
    case (m.st)
      0: if (start) begin n.st = 1; n.t = 0; end
      1: if (press) begin
        n.idx = int'(flip_sel); n.ren = 1; n.age = 1; n.st = 2;
      end
      2: if (m.age == RC) begin
        n.ren = 0; n.adv = match; n.st = match ? 3 : 5;
      end else n.age = m.age + 1;
      3: begin n.adv = 0; n.st = 4; end
      4: if (W) begin
        n.win = m.t; n.go = 1; n.st = 6;
      end else n.st = 1;
      5: begin n.t = (m.t + 1) % np; n.st = 1; end
      6: if (start) begin
        n.st = 0; n.go = 0; n.win = 0; n.t = 0;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic logic [13:0] pk(model_t m);
    return {3'(m.st), 2'(m.t), m.adv, m.ren,
            4'(m.idx), 2'(m.win), m.go};
  endfunction

  function automatic logic [13:0] pk4();
    return {if4.state, if4.T, if4.advance, if4.reveal_en,
            if4.reveal_idx, if4.winner, if4.game_over};
  endfunction

  function automatic logic [13:0] pk3();
    return {if3.state, if3.T, if3.advance, if3.reveal_en,
            if3.reveal_idx, if3.winner, if3.game_over};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m4 <= rst_m();
      m3 <= rst_m();
    end else begin
      m4 <= step(m4, 4);
      m3 <= step(m3, 3);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (pk4() !== pk(m4)) begin
        bad++;
        $display("FAIL model4 t=%0t dut=%h exp=%h",
                 $time, pk4(), pk(m4));
      end
      total++;
      if (pk3() !== pk(m3)) begin
        bad++;
        $display("FAIL model3 t=%0t dut=%h exp=%h",
                 $time, pk3(), pk(m3));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_flip(
    input  logic [3:0] sel,
    input  bit         mt,
    input  bit         w,
    output int         ren_n,
    output int         adv_n,
    output int         adv_at
  );
    bit done = 0;
    flip_sel = sel; match = mt; W = w; btn = 1;
    ren_n = 0; adv_n = 0; adv_at = -1;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (if4.reveal_en) ren_n++;
      if (if4.advance) begin adv_n++; adv_at = k; end
      if (k > 1 && (if4.state == 3'd1 || if4.state == 3'd6))
        done = 1;
      #1;
      btn = 0;
    end
    chk("flip_done", int'(done), 1);
  endtask

  int rn, an, aat;
  int e4[5] = '{2, 3, 0, 1, 2};
  int e3[5] = '{2, 0, 1, 2, 0};

  initial begin
    rst = 1; btn = 1; start = 0;
    flip_sel = 0; match = 0; W = 0;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    chk_en = 1;
    repeat (10) @(negedge clk);
    chk("idle_state", int'(if4.state), 0);
    chk("idle_T", int'(if4.T), 0);
    chk("idle_ren", int'(if4.reveal_en), 0);
    chk("idle_all", int'(pk4()), 0);

    #1 btn = 0; start = 1;
    @(negedge clk);
    chk("start_wait", int'(if4.state), 1);
    #1 start = 0;

    do_flip(4'd5, 0, 0, rn, an, aat);
    chk("miss_ren_cycles", rn, RC);
    chk("miss_adv", an, 0);
    chk("miss_idx", int'(if4.reveal_idx), 5);
    chk("miss_T", int'(if4.T), 1);

    do_flip(4'd9, 1, 0, rn, an, aat);
    chk("hit_adv_count", an, 1);
    chk("hit_adv_at", aat, RC + 1);
    chk("hit_T", int'(if4.T), 1);
    chk("hit_state", int'(if4.state), 1);

    for (int i = 0; i < 5; i++) begin
      do_flip(4'(i), 0, 0, rn, an, aat);
      chk("wrap_T4", int'(if4.T), e4[i]);
      chk("wrap_T3", int'(if3.T), e3[i]);
    end

    do_flip(4'd3, 1, 1, rn, an, aat);
    chk("win_go", int'(if4.game_over), 1);
    chk("win_winner", int'(if4.winner), 2);
    chk("win_state", int'(if4.state), 6);
    chk("win_winner3", int'(if3.winner), 0);
    W = 0;
    btn = 1;
    an = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if4.advance) an++;
      #1 btn = 0;
    end
    chk("win_press_adv", an, 0);
    chk("win_hold", int'(if4.state), 6);
    start = 1;
    @(negedge clk);
    chk("restart_idle", int'(if4.state), 0);
    chk("restart_go", int'(if4.game_over), 0);
    #1;
    @(negedge clk);
    #1 start = 0;

    btn = 1; match = 0; rn = 0; an = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (if4.reveal_en) rn++;
      if (if4.advance) an++;
      #1 btn = (k == 2);
    end
    chk("ign_ren_cycles", rn, RC);
    chk("ign_state", int'(if4.state), 1);

    btn = 1;
    cyc();
    btn = 0;
    @(negedge clk);
    chk("pre_rst_ren", int'(if4.reveal_en), 1);
    #2 rst = 0;
    #1;
    chk("async_rst4", int'(pk4()), 0);
    chk("async_rst3", int'(pk3()), 0);
    @(negedge clk);
    #1 rst = 1;

    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      flip_sel = 4'($urandom);
      match = 1'($urandom);
      W = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
